sa_result_collector: RTL and testbench
======================================

// Module: sa_result_collector
// PURPOSE
//  Drain end of the systolic array: consumes the skewed mac/mac-valid streams leaving the bottom
//  PE row, de-skews them into whole result rows, buffers rows in a FIFO and hands them to the
//  downstream consumer over a valid/ready handshake. Column c of a row arrives c cycles after column 0.
// PARAMETERS
//  COLS   8   array columns (>=2)
//  MAC_W  19  per-column accumulator width (8+8+3)
//  DEPTH  4   result-row FIFO depth (power of 2, >=2)
//  OUT_W  8   saturated element width, used only with SA_COLLECT_SAT_EN
// PORTS
//  clk_i      in   1           clock, all logic on rising edge
//  rst_i      in   1           reset, asynchronous, active-high
//  mac_i      in   COLS*MAC_W  bottom-row mac_o bus, column c at [c*MAC_W +: MAC_W]
//  mac_v_i    in   COLS        per-column mac valid
//  res_o      out  COLS*RES_W  head result row, RES_W = OUT_W (SAT_EN) else MAC_W
//  res_v_o    out  1           head row valid (FIFO not empty)
//  res_rdy_i  in   1           consumer ready
//  count_o    out  log2(DEPTH)+1  rows held in FIFO
//  overflow_o out  1           sticky: a row was dropped because FIFO full
//  skew_err_o out  1           sticky: partial row (some, not all, aligned valids)
// BEHAVIOUR
//  Reset (async, any time incl. mid-transfer): deskew regs, FIFO pointers, count_o=0, res_v_o=0,
//   res_o=0, overflow_o=0, skew_err_o=0; in-flight partial rows discarded.
//  Deskew: column c data+valid delayed by COLS-1-c registers; column COLS-1 is undelayed.
//   Aligned vector is valid when all COLS delayed valids are 1 in the same cycle.
//  Push: on the edge sampling column COLS-1 of an all-valid row; res_v_o rises after that edge,
//   i.e. COLS-1 cycles after the edge sampling column 0. Back-to-back rows every cycle supported.
//  Partial alignment (0 < valids < COLS): nothing pushed, skew_err_o set until reset.
//  Pop: edge with res_v_o && res_rdy_i advances head; res_o/res_v_o change only after a pop or a
//   push into an empty FIFO; res_o holds stable while res_v_o && !res_rdy_i.
//  Full: push without simultaneous pop drops the row, sets overflow_o, count_o stays DEPTH.
//   Push+pop same edge when full: both succeed, count_o unchanged (no overflow).
//  Empty: res_rdy_i ignored; push into empty FIFO with res_rdy_i=1 is not popped same edge.
//  Pointers wrap modulo DEPTH; count_o in 0..DEPTH.
//  Data unsigned; no arithmetic except optional saturation. res_o = 0 while empty.
// CONFIGURATION
//  SA_COLLECT_SAT_EN defined: each element written to FIFO as min(value, 2^OUT_W-1), RES_W=OUT_W;
//   storage sized COLS*OUT_W. Undefined: elements passed through at full MAC_W, RES_W=MAC_W.
//  Timing, handshake and flags identical in both builds.
// TESTING (defaults COLS=8, MAC_W=19, DEPTH=4)
//  Single row: column c value 100+c, valid skewed by c cycles, res_rdy_i=1 -> res_v_o rises 7 cycles
//   after column-0 edge, res_o = {107..100}, one cycle, count_o returns to 0.
//  Stream 6 rows back-to-back, res_rdy_i=0 -> count_o reaches 4, rows 5,6 dropped, overflow_o=1;
//   then res_rdy_i=1 -> rows 1..4 out in order, count_o 0.
//  FIFO full, push and pop same edge -> count_o stays 4, overflow_o stays 0, order preserved.
//  Column 3 valid withheld for one row -> no push, skew_err_o=1, following good row still emitted.
//  Assert rst_i mid-stream with 3 rows buffered and 4 columns in flight -> outputs zero immediately,
//   no stale row after release; next row emitted correctly.
//  SA_COLLECT_SAT_EN: elements 300, 255, 0, 0x7FFFF -> res_o elements 255, 255, 0, 255.

Source files
------------

// File: rtl/sa_result_collector.sv
// sa_result_collector: drain end of the systolic array.
// Takes the skewed mac/valid streams leaving the bottom PE row, re-aligns them
// into whole result rows, queues rows in a small FIFO and presents the head row
// to the consumer over a valid/ready handshake.
// Optional build macro: SA_COLLECT_SAT_EN -- clamps each element to
// 2^OUT_W-1 and stores/presents OUT_W-bit elements instead of MAC_W-bit ones.
module sa_result_collector #(
    parameter int COLS  = 8,
    parameter int MAC_W = 19,
    parameter int DEPTH = 4,
    parameter int OUT_W = 8,
`ifdef SA_COLLECT_SAT_EN
    localparam int RES_W = OUT_W,
`else
    // OUT_W is folded in at zero weight so both builds share one parameter list
    localparam int RES_W = MAC_W + 0 * OUT_W,
`endif
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [COLS*MAC_W-1:0]  mac_i,
    input  logic [COLS-1:0]        mac_v_i,
    output logic [COLS*RES_W-1:0]  res_o,
    output logic                   res_v_o,
    input  logic                   res_rdy_i,
    output logic [CNT_W-1:0]       count_o,
    output logic                   overflow_o,
    output logic                   skew_err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Aligned (de-skewed) per-column valids and data
    logic [COLS-1:0]        w_al_v;
    logic [MAC_W-1:0]       w_al_d [COLS];
    // Row as it will be written into the FIFO (possibly saturated)
    logic [COLS*RES_W-1:0]  w_wr_row;

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        // Column gi arrives gi cycles after column 0, so it needs COLS-1-gi
        // stages to line up with the last column, which is used undelayed.
        localparam int D = COLS - 1 - gi;
        logic [MAC_W-1:0] w_in;
        logic [RES_W-1:0] w_elem;

        assign w_in = mac_i[gi*MAC_W +: MAC_W];

        if (D == 0) begin : g_pass
            assign w_al_v[gi] = mac_v_i[gi];
            assign w_al_d[gi] = w_in;
        end else begin : g_dly
            logic [D-1:0]     r_v;
            logic [MAC_W-1:0] r_d [D];

            // Delay line for this column's data and valid
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_v <= '0;
                    for (int k = 0; k < D; k++) r_d[k] <= '0;
                end else begin
                    r_v[0] <= mac_v_i[gi];
                    r_d[0] <= w_in;
                    for (int k = 1; k < D; k++) begin
                        r_v[k] <= r_v[k-1];
                        r_d[k] <= r_d[k-1];
                    end
                end
            end

            assign w_al_v[gi] = r_v[D-1];
            assign w_al_d[gi] = r_d[D-1];
        end

`ifdef SA_COLLECT_SAT_EN
        localparam logic [MAC_W-1:0] SAT_MAX = MAC_W'((64'd1 << OUT_W) - 64'd1);
        assign w_elem = (w_al_d[gi] > SAT_MAX) ? {RES_W{1'b1}} : w_al_d[gi][RES_W-1:0];
`else
        assign w_elem = w_al_d[gi];
`endif
        assign w_wr_row[gi*RES_W +: RES_W] = w_elem;
    end

    // Result-row FIFO state
    logic [COLS*RES_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_skew_err;

    logic w_all_v;
    logic w_any_v;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_all_v = &w_al_v;
    assign w_any_v = |w_al_v;
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // An empty FIFO ignores ready, so a row pushed into it is never popped on the same edge
    assign w_pop   = !w_empty && res_rdy_i;
    // When full, a simultaneous pop frees the slot the push needs
    assign w_push  = w_all_v && (!w_full || w_pop);

    // Row storage; no reset needed since slots are only read once written
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_row;
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_all_v && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_any_v && !w_all_v)         r_skew_err <= 1'b1;
        end
    end

    // Head row is read combinationally so it appears the cycle after it is
    // written into an empty FIFO, and it is forced to zero while empty.
    assign res_o      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign res_v_o    = !w_empty;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign skew_err_o = r_skew_err;

endmodule

// File: tb/tb_sa_result_collector.sv
// Randomised scoreboard bench for sa_result_collector.
// Rows are scheduled as (start cycle, column mask, data); a row-level model
// decides at each edge whether a row completes, is accepted, dropped or flagged,
// and pushes accepted rows onto a scoreboard that a negedge monitor drains.
module tb_sa_result_collector;
    localparam int COLS  = 8;
    localparam int MAC_W = 19;
    localparam int DEPTH = 4;
    localparam int OUT_W = 8;
`ifdef SA_COLLECT_SAT_EN
    localparam int RES_W = OUT_W;
`else
    localparam int RES_W = MAC_W;
`endif
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int MAXR  = 128;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [COLS*MAC_W-1:0]  mac;
    logic [COLS-1:0]        mac_v;
    logic [COLS*RES_W-1:0]  res;
    logic                   res_v;
    logic                   rdy;
    logic [CNT_W-1:0]       count;
    logic                   ovf;
    logic                   skew;

    always #5 clk = ~clk;

    sa_result_collector #(.COLS(COLS), .MAC_W(MAC_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk_i(clk), .rst_i(rst), .mac_i(mac), .mac_v_i(mac_v),
        .res_o(res), .res_v_o(res_v), .res_rdy_i(rdy),
        .count_o(count), .overflow_o(ovf), .skew_err_o(skew)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Row schedule
    int               r_start [MAXR];
    logic [COLS-1:0]  r_mask  [MAXR];
    logic [MAC_W-1:0] r_dat   [MAXR][COLS];
    bit               r_live  [MAXR];
    int               n_rows = 0;

    // Model state
    int                    cyc = 0;
    int                    mcount = 0;
    bit                    m_ovf = 0;
    bit                    m_skew = 0;
    logic [COLS*RES_W-1:0] sb[$];
    bit                    mon_en = 0;
    bit                    rand_rdy = 0;
    int                    npop = 0;

    task automatic add_row(input int s, input logic [COLS-1:0] mask, input int kind);
        logic [MAC_W-1:0] pat [4];
        pat[0] = MAC_W'(300); pat[1] = MAC_W'(255); pat[2] = '0; pat[3] = MAC_W'(20'h7FFFF);
        if (n_rows >= MAXR) begin
            $display("FAIL row_table: got %0d rows expected below %0d", n_rows, MAXR);
            $fatal(1);
        end
        r_start[n_rows] = s;
        r_mask[n_rows]  = mask;
        r_live[n_rows]  = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            case (kind)
                0:       r_dat[n_rows][c] = MAC_W'(100 + c);
                1:       r_dat[n_rows][c] = ($urandom_range(0, 3) == 0) ? MAC_W'($urandom)
                                                                        : MAC_W'($urandom_range(0, 300));
                default: r_dat[n_rows][c] = pat[c % 4];
            endcase
        end
        n_rows++;
    endtask

    function automatic logic [COLS*RES_W-1:0] exp_row(input int i);
        logic [COLS*RES_W-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) begin
`ifdef SA_COLLECT_SAT_EN
            v[c*RES_W +: RES_W] = (int'(r_dat[i][c]) > (1 << OUT_W) - 1) ? RES_W'((1 << OUT_W) - 1)
                                                                        : RES_W'(r_dat[i][c]);
`else
            v[c*RES_W +: RES_W] = r_dat[i][c];
`endif
        end
        return v;
    endfunction

    // Effect of one clock edge on the row-level model, using pre-edge inputs
    task automatic model_edge();
        bit pop;
        if (rst) return;
        pop = (mcount > 0) && rdy;
        for (int i = 0; i < n_rows; i++) begin
            if (r_live[i] && cyc == r_start[i] + COLS) begin
                r_live[i] = 1'b0;
                if (&r_mask[i]) begin
                    if (mcount < DEPTH || pop) begin
                        sb.push_back(exp_row(i));
                        mcount++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else begin
                    m_skew = 1'b1;
                end
            end
        end
        if (pop) mcount--;
    endtask

    task automatic drive();
        mac_v = '0;
        mac   = '0;
        for (int i = 0; i < n_rows; i++) begin
            if (r_live[i]) begin
                int d;
                d = cyc - r_start[i];
                if (d >= 0 && d < COLS && r_mask[i][d]) begin
                    mac_v[d] = 1'b1;
                    mac[d*MAC_W +: MAC_W] = r_dat[i][d];
                end
            end
        end
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        drive();
    endtask

    // Monitor: compares flags every cycle, pops the scoreboard on each handshake
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("count_o", count, mcount);
            chk("res_v_o", res_v, mcount > 0);
            chk("overflow_o", ovf, m_ovf);
            chk("skew_err_o", skew, m_skew);
            if (res_v) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("res_o", res, sb[0]);
                    if (rdy) begin
                        $display("pop row %0d data=%0h t=%0t", npop, res, $time);
                        void'(sb.pop_front());
                        npop++;
                    end
                end
            end else begin
                chk("res_o_idle", res, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        int p0;
        logic [COLS*RES_W-1:0] e;
        rst = 1'b1; rdy = 1'b0; mac = '0; mac_v = '0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_res_v", res_v, 0);
        chk("rst_res", res, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_skew", skew, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single row, ready high: valid rises COLS-1 cycles after column-0 edge
        rdy = 1'b1;
        s = cyc + 1;
        add_row(s, '1, 0);
        while (cyc < s + COLS - 1) step();
        chk("single_pre_v", res_v, 0);
        step();
        chk("single_v", res_v, 1);
        e = '0;
        for (int c = 0; c < COLS; c++) e[c*RES_W +: RES_W] = RES_W'(100 + c);
        chk("single_data", res, e);
        step();
        chk("single_after_v", res_v, 0);
        chk("single_after_cnt", count, 0);

        // Fill to DEPTH, then push and pop on the same edge while full
        rdy = 1'b0;
        s = cyc + 1;
        for (int k = 0; k <= DEPTH; k++) add_row(s + k, '1, 1);
        while (cyc < s + DEPTH + COLS - 1) step();
        chk("full_cnt", count, DEPTH);
        rdy = 1'b1;
        step();
        chk("full_pushpop_cnt", count, DEPTH);
        chk("full_pushpop_ovf", ovf, 0);
        repeat (DEPTH + 3) step();
        chk("full_drain_cnt", count, 0);

        // Column 3 withheld for one row, good row right behind it
        p0 = npop;
        add_row(cyc + 1, ~(COLS'(1) << 3), 1);
        add_row(cyc + 2, '1, 0);
        repeat (COLS + 6) step();
        chk("skew_flag", skew, 1);
        chk("skew_good_row", npop - p0, 1);

        // Six rows back-to-back with ready low: two dropped
        rdy = 1'b0;
        s = cyc + 1;
        for (int k = 0; k < 6; k++) add_row(s + k, '1, 1);
        repeat (COLS + 8) step();
        chk("ovf_cnt", count, DEPTH);
        chk("ovf_flag", ovf, 1);
        p0 = npop;
        rdy = 1'b1;
        repeat (DEPTH + 4) step();
        chk("ovf_drain_cnt", count, 0);
        chk("ovf_drain_rows", npop - p0, DEPTH);

        // Reset with three rows buffered and four columns of a fourth in flight
        rdy = 1'b0;
        s = cyc + 1;
        for (int k = 0; k < 3; k++) add_row(s + k, '1, 1);
        add_row(s + COLS, '1, 1);
        while (cyc < s + COLS + 4) step();
        chk("prerst_cnt", count, 3);
        rst = 1'b1;
        for (int i = 0; i < n_rows; i++) r_live[i] = 1'b0;
        sb.delete();
        mcount = 0; m_ovf = 1'b0; m_skew = 1'b0;
        drive();
        #1;
        chk("midrst_cnt", count, 0);
        chk("midrst_res_v", res_v, 0);
        chk("midrst_res", res, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_skew", skew, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (COLS + 2) step();
        chk("postrst_stale_v", res_v, 0);
        p0 = npop;
        rdy = 1'b1;
        add_row(cyc + 1, '1, 2);
        repeat (COLS + 3) step();
        chk("postrst_row", npop - p0, 1);

        // Random traffic with random ready and occasional partial rows
        rand_rdy = 1'b1;
        s = cyc + 2;
        for (int k = 0; k < 40; k++) begin
            logic [COLS-1:0] m;
            m = ($urandom_range(0, 7) == 0) ? ~(COLS'(1) << $urandom_range(0, COLS - 1)) : '1;
            add_row(s, m, 1);
            s += $urandom_range(1, 3);
        end
        while (cyc < s + COLS + 2) step();
        rand_rdy = 1'b0;
        rdy = 1'b1;
        repeat (DEPTH + 4) step();
        chk("rand_drain_cnt", count, 0);
        chk("rand_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
